vram_arbiter: RTL and testbench

Shares the single-port VRAM block RAM between the background fetcher, the sprite fetcher and the CPU bus. The PPU mode decides which requesters may own the RAM. The arbiter tracks in-flight reads through the RAM's fixed read latency and returns each byte to the requester that issued it. It sits between the fetchers/CPU bus and the VRAM BRAM instance in the PPU top level.

---
 rtl/ppu_pkg.sv | 14 +
 rtl/ReqLatch.sv | 35 +++
 rtl/vram_arbiter.sv | 96 +++++++++
 tb/tb_vram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared PPU mode/owner types and VRAM window constants
package ppu_pkg;
  typedef enum logic [1:0] {HBlank = 2'd0, VBlank = 2'd1, OamScan = 2'd2, Drawing = 2'd3} PpuMode;
  typedef enum logic [1:0] {OwnBg, OwnSpr, OwnCpu} VramOwner;
  typedef struct packed {
    logic     v;
    VramOwner own;
  } vram_tag_t;
  localparam logic [15:0] VRAM_BASE = 16'h8000;
  localparam logic [15:0] VRAM_END = 16'h9FFF;
  function automatic logic in_vram(input logic [15:0] a);
    return a >= VRAM_BASE && a <= VRAM_END;
  endfunction
endpackage

// File: rtl/ReqLatch.sv
// ReqLatch: one-shot request latch with sticky returned byte and valid flag
module ReqLatch (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       req_in,
  input  logic       issue_in,
  input  logic       reject_in,
  input  logic       deliver_in,
  input  logic [7:0] rdata_in,
  output logic       pending_out,
  output logic [7:0] data_out,
  output logic       valid_out
);
  logic served_q, served_d, valid_q, valid_d;
  logic [7:0] data_q, data_d;
  assign pending_out = req_in & ~served_q;
  assign data_out = data_q;
  assign valid_out = valid_q;
  always_comb begin
    served_d = req_in & (served_q | issue_in | reject_in);
    valid_d = deliver_in | (req_in & valid_q);
    data_d = deliver_in ? rdata_in : data_q;
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      served_q <= 1'b0;
      valid_q <= 1'b0;
      data_q <= 8'h00;
    end else begin
      served_q <= served_d;
      valid_q <= valid_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: mode-aware VRAM sharing between bg/sprite fetchers and CPU with pipelined read return
module vram_arbiter
  import ppu_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [1:0]  mode_in,
  input  logic        bg_req_in,
  input  logic [15:0] bg_addr_in,
  output logic [7:0]  bg_data_out,
  output logic        bg_valid_out,
  input  logic        spr_req_in,
  input  logic [15:0] spr_addr_in,
  output logic [7:0]  spr_data_out,
  output logic        spr_valid_out,
  input  logic        cpu_rd_in,
  input  logic        cpu_wr_in,
  input  logic [15:0] cpu_addr_in,
  input  logic [7:0]  cpu_wdata_in,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_valid_out,
  output logic [12:0] vram_addr_out,
  output logic        vram_we_out,
  output logic [7:0]  vram_wdata_out,
  input  logic [7:0]  vram_rdata_in
);
  vram_tag_t tag_q [READ_LATENCY];
  vram_tag_t tag_d, tag_out;
  logic drawing, bg_pend, spr_pend, spr_issue, bg_issue, spr_rej, bg_rej;
  logic cpu_wr_issue, cpu_rd_issue, cpu_ff_q, cpu_ff_d;
  logic bg_dlv, spr_dlv, cpu_dlv;
  logic [12:0] vram_addr_q, vram_addr_d;
  logic vram_we_q, vram_we_d, cpu_valid_q, cpu_valid_d;
  logic [7:0] vram_wdata_q, vram_wdata_d, cpu_data_q, cpu_data_d;
  assign tag_out = tag_q[READ_LATENCY-1];
  always_comb begin
    drawing = PpuMode'(mode_in) == Drawing;
    spr_issue = drawing & spr_pend & in_vram(spr_addr_in);
    spr_rej = spr_pend & ~spr_issue;
    bg_issue = drawing & bg_pend & in_vram(bg_addr_in) & ~spr_issue;
    bg_rej = bg_pend & (~drawing | ~in_vram(bg_addr_in));
    cpu_wr_issue = ~drawing & cpu_wr_in & in_vram(cpu_addr_in);
    // a simultaneous write takes the port, so the read falls back to 0xFF
    cpu_rd_issue = ~drawing & cpu_rd_in & ~cpu_wr_in & in_vram(cpu_addr_in);
    cpu_ff_d = cpu_rd_in & ~cpu_rd_issue;
    tag_d.v = spr_issue | bg_issue | cpu_rd_issue;
    tag_d.own = spr_issue ? OwnSpr : bg_issue ? OwnBg : OwnCpu;
    vram_addr_d = spr_issue ? spr_addr_in[12:0] :
                  bg_issue ? bg_addr_in[12:0] :
                  (cpu_rd_issue | cpu_wr_issue) ? cpu_addr_in[12:0] : vram_addr_q;
    vram_we_d = cpu_wr_issue;
    vram_wdata_d = cpu_wr_issue ? cpu_wdata_in : vram_wdata_q;
    bg_dlv = tag_out.v & (tag_out.own == OwnBg);
    spr_dlv = tag_out.v & (tag_out.own == OwnSpr);
    cpu_dlv = tag_out.v & (tag_out.own == OwnCpu);
    cpu_valid_d = cpu_dlv | cpu_ff_q;
    cpu_data_d = cpu_dlv ? vram_rdata_in : cpu_ff_q ? 8'hFF : cpu_data_q;
  end
  ReqLatch u_bg (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(bg_req_in), .issue_in(bg_issue),
    .reject_in(bg_rej), .deliver_in(bg_dlv), .rdata_in(vram_rdata_in),
    .pending_out(bg_pend), .data_out(bg_data_out), .valid_out(bg_valid_out)
  );
  ReqLatch u_spr (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(spr_req_in), .issue_in(spr_issue),
    .reject_in(spr_rej), .deliver_in(spr_dlv), .rdata_in(vram_rdata_in),
    .pending_out(spr_pend), .data_out(spr_data_out), .valid_out(spr_valid_out)
  );
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
      vram_addr_q <= '0;
      vram_we_q <= 1'b0;
      vram_wdata_q <= '0;
      cpu_ff_q <= 1'b0;
      cpu_valid_q <= 1'b0;
      cpu_data_q <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      vram_addr_q <= vram_addr_d;
      vram_we_q <= vram_we_d;
      vram_wdata_q <= vram_wdata_d;
      cpu_ff_q <= cpu_ff_d;
      cpu_valid_q <= cpu_valid_d;
      cpu_data_q <= cpu_data_d;
    end
  end
  assign vram_addr_out = vram_addr_q;
  assign vram_we_out = vram_we_q;
  assign vram_wdata_out = vram_wdata_q;
  assign cpu_data_out = cpu_data_q;
  assign cpu_valid_out = cpu_valid_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and randomized checks against a behavioural arbiter model
module tb_vram_arbiter;
  localparam int L = 2;
  logic clk_in = 1'b0, rst_in = 1'b0;
  logic [1:0] mode_in = 2'd0;
  logic bg_req_in = 1'b0, spr_req_in = 1'b0, cpu_rd_in = 1'b0, cpu_wr_in = 1'b0;
  logic [15:0] bg_addr_in = 16'h8000, spr_addr_in = 16'h8000, cpu_addr_in = 16'h8000;
  logic [7:0] cpu_wdata_in = 8'h00;
  logic [7:0] bg_data_out, spr_data_out, cpu_data_out, vram_wdata_out, vram_rdata_in;
  logic bg_valid_out, spr_valid_out, cpu_valid_out, vram_we_out;
  logic [12:0] vram_addr_out;

  vram_arbiter #(.READ_LATENCY(L)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .mode_in(mode_in),
    .bg_req_in(bg_req_in), .bg_addr_in(bg_addr_in), .bg_data_out(bg_data_out), .bg_valid_out(bg_valid_out),
    .spr_req_in(spr_req_in), .spr_addr_in(spr_addr_in), .spr_data_out(spr_data_out), .spr_valid_out(spr_valid_out),
    .cpu_rd_in(cpu_rd_in), .cpu_wr_in(cpu_wr_in), .cpu_addr_in(cpu_addr_in), .cpu_wdata_in(cpu_wdata_in),
    .cpu_data_out(cpu_data_out), .cpu_valid_out(cpu_valid_out),
    .vram_addr_out(vram_addr_out), .vram_we_out(vram_we_out), .vram_wdata_out(vram_wdata_out),
    .vram_rdata_in(vram_rdata_in)
  );

  always #5 clk_in = ~clk_in;

  // block RAM: registered read, so data follows the arbiter's registered address by one more edge
  logic [7:0] ram [8192];
  logic [7:0] ram_q = 8'h00;
  always @(posedge clk_in) begin
    if (vram_we_out) ram[vram_addr_out] <= vram_wdata_out;
    ram_q <= ram[vram_addr_out];
  end
  assign vram_rdata_in = ram_q;

  int errors = 0, checks = 0, cyc = 0;
  typedef struct { int due; int own; logic [7:0] data; } dlv_t;
  dlv_t dq[$];
  logic [7:0] ref_mem [8192];
  bit bg_served, spr_served, e_bg_v, e_spr_v, e_cpu_v, e_we;
  logic [7:0] e_bg_d, e_spr_d, e_cpu_d, e_wdata;
  logic [12:0] e_addr;

  task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit inr(logic [15:0] a);
    return a >= 16'h8000 && a <= 16'h9FFF;
  endfunction

  task automatic push(int due, int own, logic [7:0] data);
    dlv_t d;
    d.due = due;
    d.own = own;
    d.data = data;
    dq.push_back(d);
  endtask

  task automatic issue(logic [15:0] a, int own);
    push(cyc + L, own, ref_mem[a - 16'h8000]);
    e_addr = 13'(a - 16'h8000);
  endtask

  task automatic model_reset();
    dq.delete();
    bg_served = 0; spr_served = 0;
    e_bg_v = 0; e_spr_v = 0; e_cpu_v = 0; e_we = 0;
    e_bg_d = 0; e_spr_d = 0; e_cpu_d = 0; e_wdata = 0; e_addr = 0;
  endtask

  // own codes: 0 bg, 1 sprite, 2 CPU RAM read, 3 CPU 0xFF answer
  task automatic model_edge();
    bit draw, bg_p, spr_p, spr_go, bg_go, cw, cr, bg_hit, spr_hit, cr_hit, ff_hit;
    logic [7:0] bg_x, spr_x, cr_x;
    draw = mode_in == 2'd3;
    bg_p = bg_req_in && !bg_served;
    spr_p = spr_req_in && !spr_served;
    spr_go = draw && spr_p && inr(spr_addr_in);
    bg_go = draw && bg_p && !spr_go && inr(bg_addr_in);
    cw = !draw && cpu_wr_in && inr(cpu_addr_in);
    cr = !draw && cpu_rd_in && !cpu_wr_in && inr(cpu_addr_in);
    e_we = cw;
    if (spr_go) issue(spr_addr_in, 1);
    if (bg_go) issue(bg_addr_in, 0);
    if (cr) issue(cpu_addr_in, 2);
    if (cpu_rd_in && !cr) push(cyc + 1, 3, 8'hFF);
    if (cw) begin
      e_addr = 13'(cpu_addr_in - 16'h8000);
      e_wdata = cpu_wdata_in;
      ref_mem[cpu_addr_in - 16'h8000] = cpu_wdata_in;
    end
    if (!bg_req_in) bg_served = 0;
    else if (bg_go || (bg_p && (!draw || !inr(bg_addr_in)))) bg_served = 1;
    if (!spr_req_in) spr_served = 0;
    else if (spr_p) spr_served = 1;
    bg_hit = 0; spr_hit = 0; cr_hit = 0; ff_hit = 0;
    bg_x = 0; spr_x = 0; cr_x = 0;
    for (int i = dq.size() - 1; i >= 0; i--) begin
      if (dq[i].due == cyc) begin
        if (dq[i].own == 0) begin bg_hit = 1; bg_x = dq[i].data; end
        else if (dq[i].own == 1) begin spr_hit = 1; spr_x = dq[i].data; end
        else if (dq[i].own == 2) begin cr_hit = 1; cr_x = dq[i].data; end
        else ff_hit = 1;
        dq.delete(i);
      end
    end
    e_bg_v = bg_hit || (bg_req_in && e_bg_v);
    if (bg_hit) e_bg_d = bg_x;
    e_spr_v = spr_hit || (spr_req_in && e_spr_v);
    if (spr_hit) e_spr_d = spr_x;
    e_cpu_v = cr_hit || ff_hit;
    if (cr_hit) e_cpu_d = cr_x;
    else if (ff_hit) e_cpu_d = 8'hFF;
    cyc++;
  endtask

  task automatic compare();
    check("bg_valid", 16'(bg_valid_out), 16'(e_bg_v));
    check("bg_data", 16'(bg_data_out), 16'(e_bg_d));
    check("spr_valid", 16'(spr_valid_out), 16'(e_spr_v));
    check("spr_data", 16'(spr_data_out), 16'(e_spr_d));
    check("cpu_valid", 16'(cpu_valid_out), 16'(e_cpu_v));
    check("cpu_data", 16'(cpu_data_out), 16'(e_cpu_d));
    check("vram_we", 16'(vram_we_out), 16'(e_we));
    check("vram_addr", 16'(vram_addr_out), 16'(e_addr));
    check("vram_wdata", 16'(vram_wdata_out), 16'(e_wdata));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_in);
    #1;
    compare();
  endtask

  task automatic clr();
    cpu_rd_in = 0;
    cpu_wr_in = 0;
  endtask

  function automatic logic [15:0] rnd_addr();
    case ($urandom_range(7))
      0: return 16'h7FFF;
      1: return 16'hA000;
      2: return 16'h9FFF;
      3: return 16'($urandom);
      default: return 16'h8000 + 16'($urandom_range(15)) + ($urandom_range(1) == 1 ? 16'h1800 : 16'h0000);
    endcase
  endfunction

  task automatic check_reset_outputs(string tag);
    check({tag, "_bg_v"}, 16'(bg_valid_out), 16'h0);
    check({tag, "_bg_d"}, 16'(bg_data_out), 16'h0);
    check({tag, "_spr_v"}, 16'(spr_valid_out), 16'h0);
    check({tag, "_spr_d"}, 16'(spr_data_out), 16'h0);
    check({tag, "_cpu_v"}, 16'(cpu_valid_out), 16'h0);
    check({tag, "_cpu_d"}, 16'(cpu_data_out), 16'h0);
    check({tag, "_addr"}, 16'(vram_addr_out), 16'h0);
    check({tag, "_we"}, 16'(vram_we_out), 16'h0);
    check({tag, "_wdata"}, 16'(vram_wdata_out), 16'h0);
  endtask

  initial begin
    logic [15:0] bnd [4];
    bnd[0] = 16'h7FFF; bnd[1] = 16'h8000; bnd[2] = 16'h9FFF; bnd[3] = 16'hA000;
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'($urandom);
    ref_mem[13'h1800] = 8'h12;
    ref_mem[13'h0001] = 8'hA1;
    ref_mem[13'h1801] = 8'hB2;
    ref_mem[13'h1802] = 8'hC3;
    for (int i = 0; i < 8192; i++) ram[i] = ref_mem[i];
    #1 rst_in = 1;
    #2 check_reset_outputs("rst0");
    @(posedge clk_in);
    @(posedge clk_in);
    #1 rst_in = 0;
    model_reset();

    // mode 0 CPU write then read back
    mode_in = 2'd0;
    cpu_wr_in = 1; cpu_addr_in = 16'h8010; cpu_wdata_in = 8'h5A;
    step();
    check("t1_we", 16'(vram_we_out), 16'h1);
    check("t1_addr", 16'(vram_addr_out), 16'h0010);
    clr(); cpu_rd_in = 1;
    step();
    clr();
    step();
    check("t1_early_valid", 16'(cpu_valid_out), 16'h0);
    step();
    check("t1_rd_valid", 16'(cpu_valid_out), 16'h1);
    check("t1_rd_data", 16'(cpu_data_out), 16'h005A);
    step();

    // mode 3 held bg request issues once
    mode_in = 2'd3;
    bg_req_in = 1; bg_addr_in = 16'h9800;
    repeat (3) step();
    check("t2_bg_data", 16'(bg_data_out), 16'h0012);
    check("t2_bg_valid", 16'(bg_valid_out), 16'h1);
    step();
    bg_req_in = 0;
    step();
    check("t2_bg_drop", 16'(bg_valid_out), 16'h0);

    // simultaneous bg/spr requests, sprite first
    bg_req_in = 1; bg_addr_in = 16'h9801;
    spr_req_in = 1; spr_addr_in = 16'h8001;
    repeat (3) step();
    check("t3_spr_data", 16'(spr_data_out), 16'h00A1);
    check("t3_bg_not_yet", 16'(bg_valid_out), 16'h0);
    step();
    check("t3_bg_data", 16'(bg_data_out), 16'h00B2);
    check("t3_spr_keep", 16'(spr_data_out), 16'h00A1);
    bg_req_in = 0; spr_req_in = 0;
    step();

    // mode 3 CPU read answered 0xFF, write dropped
    cpu_rd_in = 1; cpu_addr_in = 16'h8000;
    step();
    clr();
    step();
    check("t4_ff_valid", 16'(cpu_valid_out), 16'h1);
    check("t4_ff_data", 16'(cpu_data_out), 16'h00FF);
    cpu_wr_in = 1; cpu_wdata_in = 8'h77;
    step();
    check("t4_no_we", 16'(vram_we_out), 16'h0);
    clr();
    step();

    // read issued in mode 3 survives switch to mode 0; new request then rejected
    bg_req_in = 1; bg_addr_in = 16'h9802;
    step();
    mode_in = 2'd0;
    step();
    step();
    check("t5_bg_data", 16'(bg_data_out), 16'h00C3);
    check("t5_bg_valid", 16'(bg_valid_out), 16'h1);
    bg_req_in = 0;
    step();
    bg_req_in = 1;
    repeat (3) step();
    check("t5_rej_valid", 16'(bg_valid_out), 16'h0);
    check("t5_rej_data", 16'(bg_data_out), 16'h00C3);
    bg_req_in = 0;
    step();

    // address window boundaries and read+write collision in mode 0
    foreach (bnd[i]) begin
      cpu_rd_in = 1; cpu_addr_in = bnd[i];
      step();
      clr();
      repeat (2) step();
    end
    cpu_rd_in = 1; cpu_wr_in = 1; cpu_addr_in = 16'h8020; cpu_wdata_in = 8'h66;
    step();
    check("t6_rw_we", 16'(vram_we_out), 16'h1);
    clr();
    step();
    check("t6_rw_ff", 16'(cpu_data_out), 16'h00FF);
    step();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(15) == 0) mode_in = 2'($urandom_range(3));
      if (!bg_req_in) begin
        if ($urandom_range(2) == 0) begin bg_req_in = 1; bg_addr_in = rnd_addr(); end
      end else if ($urandom_range(3) == 0) bg_req_in = 0;
      if (!spr_req_in) begin
        if ($urandom_range(2) == 0) begin spr_req_in = 1; spr_addr_in = rnd_addr(); end
      end else if ($urandom_range(3) == 0) spr_req_in = 0;
      cpu_rd_in = $urandom_range(3) == 0;
      cpu_wr_in = $urandom_range(4) == 0;
      cpu_addr_in = rnd_addr();
      cpu_wdata_in = 8'($urandom);
      step();
    end
    clr(); bg_req_in = 0; spr_req_in = 0;
    repeat (4) step();

    // reset with two reads in flight
    mode_in = 2'd3;
    spr_req_in = 1; spr_addr_in = 16'h8001;
    step();
    bg_req_in = 1; bg_addr_in = 16'h9801;
    step();
    rst_in = 1;
    #1 check_reset_outputs("rst1");
    bg_req_in = 0; spr_req_in = 0;
    @(posedge clk_in);
    @(posedge clk_in);
    #1 rst_in = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_no_bg_valid", 16'(bg_valid_out), 16'h0);
      check("rst_no_spr_valid", 16'(spr_valid_out), 16'h0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
